// File: rtl/dual_port_ram.sv
// 4096 x 64 dual-port synchronous RAM: one write port, one registered read port, write-first on collision.
// Define RAM_INIT_EN to enable the post-reset clear sweep that zeroes the array before init_done rises.
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  init_done
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  init_done_q, init_done_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef RAM_INIT_EN
    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_ptr_q, clr_ptr_d;

    // Extra pointer bit keeps the terminal compare unambiguous against wrap to 0.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                clr_ptr_d = clr_ptr_q + (ADDR_WIDTH+1)'(1);
                if (clr_ptr_q == (ADDR_WIDTH+1)'(DEPTH - 1)) begin
                    state_d     = READY;
                    init_done_d = 1'b1;
                end
            end
            READY: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_address;
        mem_wdata = data_in;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
        end else if (write) begin
            mem_we = 1'b1;
        end
    end
`else
    always_comb begin
        init_done_d = 1'b1;
    end

    always_comb begin
        mem_we    = init_done_q & write;
        mem_waddr = wr_address;
        mem_wdata = data_in;
    end
`endif

    // Read path: write-first bypass when both ports hit the same word on one edge.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (init_done_q && read) begin
            rd_valid_d = 1'b1;
            if (write && (wr_address == rd_address)) begin
                data_out_d = data_in;
            end else begin
                data_out_d = mem[rd_address];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench for dual_port_ram: a cycle-level reference model queues expected reads,
// a negedge monitor pops and compares them. Works with or without RAM_INIT_EN.
module tb_dual_port_ram;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;
`ifdef RAM_INIT_EN
    localparam int unsigned INIT_CYC = DEPTH;
`else
    localparam int unsigned INIT_CYC = 1;
`endif

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] wr_address = '0;
    logic          write = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic          read = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          init_done;

    dual_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .wr_address(wr_address),
        .write     (write),
        .rd_address(rd_address),
        .read      (read),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          known;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    int unsigned   ready_cnt = 0;
    bit            in_reset  = 1'b0;
    int            checks    = 0;
    int            errors    = 0;
    logic          last_known = 1'b1;
    logic [DW-1:0] last_data  = '0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_known[i] = 1'b0;
            ref_mem[i]   = '0;
        end
    end

    // Reference model: ports only count once the array is ready; collisions return the new data.
    always @(posedge clock) begin
        exp_t e;
        if (!resetn) begin
            ready_cnt = 0;
            if (!in_reset) begin
                in_reset = 1'b1;
`ifdef RAM_INIT_EN
                for (int i = 0; i < int'(DEPTH); i++) begin
                    ref_mem[i]   = '0;
                    ref_known[i] = 1'b1;
                end
`endif
            end
        end else begin
            in_reset = 1'b0;
            if (ready_cnt >= INIT_CYC) begin
                if (read) begin
                    if (write && wr_address == rd_address) begin
                        e.known = 1'b1;
                        e.data  = data_in;
                    end else begin
                        e.known = ref_known[rd_address];
                        e.data  = ref_mem[rd_address];
                    end
                    exp_q.push_back(e);
                end
                if (write) begin
                    ref_mem[wr_address]   = data_in;
                    ref_known[wr_address] = 1'b1;
                end
            end else begin
                ready_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            exp_q.delete();
            last_known = 1'b1;
            last_data  = '0;
            chk("reset_init_done", {63'b0, init_done}, '0);
            chk("reset_rd_valid", {63'b0, rd_valid}, '0);
            chk("reset_data_out", data_out, '0);
        end else begin
            chk("init_done", {63'b0, init_done}, {63'b0, (ready_cnt >= INIT_CYC)});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid_high", {63'b0, rd_valid}, 64'd1);
                if (e.known) begin
                    chk("read_data", data_out, e.data);
                end
                last_known = e.known;
                last_data  = e.data;
            end else begin
                chk("rd_valid_low", {63'b0, rd_valid}, '0);
                if (last_known) begin
                    chk("hold_data", data_out, last_data);
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra);
        write      = w;
        wr_address = wa;
        data_in    = wd;
        read       = r;
        rd_address = ra;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, '0, '0, 1'b0, '0);
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] b;

        // Reset, then hold a read at 0x7FF through init and beyond.
        write = 1'b0;
        read  = 1'b1;
        rd_address = 12'h7FF;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        for (int i = 0; i < int'(INIT_CYC) + 3; i++) begin
            cyc(1'b0, '0, '0, 1'b1, 12'h7FF);
        end

        // Write then read at both address extremes.
        cyc(1'b1, 12'h000, 64'hDEAD_BEEF_0123_4567, 1'b0, '0);
        cyc(1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 12'h000);
        cyc(1'b0, '0, '0, 1'b1, 12'hFFF);
        idle(1);

        // Collision on 0x123.
        cyc(1'b1, 12'h123, 64'h1, 1'b0, '0);
        cyc(1'b1, 12'h123, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 12'h123);
        cyc(1'b0, '0, '0, 1'b1, 12'h123);
        idle(1);

        // Streaming writes with reads lagging by one.
        for (int i = 0; i < int'(DEPTH); i++) begin
            a = AW'(i);
            b = AW'(i - 1);
            cyc(1'b1, a, DW'(i), (i > 0), b);
        end
        cyc(1'b0, '0, '0, 1'b1, 12'hFFF);

        // Hold behaviour.
        cyc(1'b1, 12'h055, 64'h55, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 12'h055);
        idle(3);

        // Random traffic over a small window to force collisions.
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), {$urandom, $urandom},
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
        end

        // Reset from READY, then reset again mid-init.
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, AW'(i), {$urandom, $urandom}, 1'b1, 12'h7FF);
        end
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        for (int i = 0; i < int'(INIT_CYC) + 5; i++) begin
            cyc(1'b0, '0, '0, 1'b1, AW'($urandom_range(0, 63)));
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, '0, '0, 1'b1, AW'(i));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

Dual-port 4096 x 64 synchronous RAM: the responder on the write and read ports driven by the RAM write and read drivers. One write port and one registered read port operate independently every cycle. A read of the address being written in the same cycle returns the new data. An optional power-up clear sweep zeroes the array after reset.

## Interface
- DATA_WIDTH, 64, word width in bits
- ADDR_WIDTH, 12, address width in bits
- DEPTH, 4096, number of words; must equal 2**ADDR_WIDTH
- clock  input  1  rising-edge clock; the only clock in the block
- resetn  input  1  asynchronous, active-low reset
- data_in  input  DATA_WIDTH  write data
- wr_address  input  ADDR_WIDTH  write address
- write  input  1  write enable, sampled on rising edge
- rd_address  input  ADDR_WIDTH  read address
- read  input  1  read enable, sampled on rising edge
- data_out  output  DATA_WIDTH  registered read data
- rd_valid  output  1  data_out was updated by the read accepted on the previous edge
- init_done  output  1  array is ready; ports are ignored while low

## Operation
- Reset: data_out = 0, rd_valid = 0, init_done = 0, FSM = INIT (or READY when the macro is absent). Array contents are not reset by resetn directly.
- FSM states:
  - INIT: clear pointer counts 0 to DEPTH-1, writing 0 to one word per cycle. After writing word DEPTH-1, go to READY and set init_done = 1.
  - READY: normal operation; terminal state until the next reset.
- In INIT, write and read are ignored: no array update, data_out holds 0, rd_valid = 0.
- In READY, write = 1 stores data_in at mem[wr_address] on the edge.
- In READY, read = 1 loads data_out with mem[rd_address] on the edge and sets rd_valid = 1 for that cycle.
- read = 0 leaves data_out holding its last value and clears rd_valid to 0.
- Collision: write = 1 and read = 1 with rd_address == wr_address on the same edge. data_out takes data_in (write-first bypass), and the array is updated.
- Different addresses on the same edge: fully independent.
- Back-to-back reads and writes every cycle: no stalls and no bubbles.
- Address width exactly covers DEPTH; there is no out-of-range case.
- Clear pointer is ADDR_WIDTH+1 bits, so the terminal count is detected without wrap ambiguity.

## Timing
- Write latency: a word written at edge N is readable by a read presented at edge N+1. At edge N itself it is visible only through the collision bypass.
- Read latency: 1 cycle. read/rd_address sampled at edge N produce data_out/rd_valid valid after edge N, which a monitor samples at edge N+1.
- rd_valid is a single-cycle pulse per accepted read. It stays high continuously under continuous reads.
- Init: init_done rises after edge DEPTH counted from the first edge with resetn high, i.e. 4096 cycles.
- Reset asserted mid-INIT: immediately forces the reset values. The sweep restarts from address 0 after release.
- Reset asserted in READY: outputs go to their reset values asynchronously. With RAM_INIT_EN the array is re-cleared after release.

## Configuration
- RAM_INIT_EN
  - Defined: INIT sweep as above; array is all-zero when init_done rises.
  - Undefined: no sweep and no clear pointer. init_done goes to 1 on the first rising edge after resetn release, and ports are ignored until then. Array contents are undefined until written (X in simulation).

## Test plan
- Reset and init (RAM_INIT_EN): release resetn, hold read = 1 at address 0x7FF. Required: rd_valid = 0 and data_out = 0 throughout init; init_done rises after 4096 cycles; next read of 0x7FF returns 0x0.
- Write then read: write 0xDEAD_BEEF_0123_4567 to 0x000 and 0xFFFF_FFFF_FFFF_FFFF to 0xFFF, then read both. Required: each value appears one cycle after its read, with rd_valid = 1.
- Collision: same edge write 0xA5A5_A5A5_A5A5_A5A5 to 0x123 and read 0x123, where 0x123 previously held 0x1. Required: data_out = 0xA5A5_A5A5_A5A5_A5A5 next cycle.
- Streaming: 4096 consecutive writes, address = data = i, overlapped with reads lagging by 1 cycle. Required: data_out = i-1 every cycle and rd_valid continuously 1.
- Hold: read 0x055 holding 0x55, then read = 0 for 3 cycles. Required: data_out stays 0x55 and rd_valid = 0.
- Reset mid-init: assert resetn low at init cycle 1000 for 2 cycles. Required: init_done stays 0, and it rises 4096 cycles after the second release.
